// File: rtl/twi_pkg.sv
// rtl/twi_pkg.sv - shared state encoding and constants for the TWI target
package twi_pkg;

   localparam int TWI_SYNC_STAGES = 2;
   localparam int TWI_BITS        = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_ADDR_ACK,
      ST_WR_DATA,
      ST_WR_ACK,
      ST_RD_DATA,
      ST_RD_ACK
   } twi_state_e;

endpackage

// File: rtl/twi_bus_sync.sv
// rtl/twi_bus_sync.sv - SCL/SDA synchronizers with edge and START/STOP detection
module twi_bus_sync
   import twi_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic scl_i,
   input  logic sda_i,
   output logic sda_o,
   output logic scl_rise,
   output logic scl_fall,
   output logic start_det,
   output logic stop_det
);

   logic [TWI_SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
   logic [TWI_SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
   logic                       scl_hist_q, scl_hist_d;
   logic                       sda_hist_q, sda_hist_d;
   logic                       scl_cur, sda_cur;

   assign scl_cur = scl_sync_q[TWI_SYNC_STAGES-1];
   assign sda_cur = sda_sync_q[TWI_SYNC_STAGES-1];

   always_comb begin
      scl_sync_d = {scl_sync_q[TWI_SYNC_STAGES-2:0], scl_i};
      sda_sync_d = {sda_sync_q[TWI_SYNC_STAGES-2:0], sda_i};
      scl_hist_d = scl_cur;
      sda_hist_d = sda_cur;
   end

   // Idle bus is high, so reset to 1 to avoid a phantom edge on release.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scl_sync_q <= '1;
         sda_sync_q <= '1;
         scl_hist_q <= 1'b1;
         sda_hist_q <= 1'b1;
      end else begin
         scl_sync_q <= scl_sync_d;
         sda_sync_q <= sda_sync_d;
         scl_hist_q <= scl_hist_d;
         sda_hist_q <= sda_hist_d;
      end
   end

   assign sda_o     = sda_cur;
   assign scl_rise  = ~scl_hist_q & scl_cur;
   assign scl_fall  = scl_hist_q & ~scl_cur;
   assign start_det = scl_hist_q & scl_cur & sda_hist_q & ~sda_cur;
   assign stop_det  = scl_hist_q & scl_cur & ~sda_hist_q & sda_cur;

endmodule

// File: rtl/twi_slave.sv
// rtl/twi_slave.sv - TWI target with auto-incrementing pointer into a local register file
// Local side port shares the register file; a same-cycle bus write takes priority.
module twi_slave
   import twi_pkg::*;
#(
   parameter logic [6:0] SLV_ADDR = 7'h50,
   parameter int         AW       = 3
)(
   input  logic          CLK_I,
   input  logic          RST_I,
   input  logic          TWI_SCL_I,
   input  logic          TWI_SDA_I,
   output logic          TWI_SDA_OEN,
   input  logic          LOC_WE,
   input  logic [AW-1:0] LOC_ADR,
   input  logic [7:0]    LOC_DAT_I,
   output logic [7:0]    LOC_DAT_O,
   output logic          BUS_WR_STB,
   output logic [AW-1:0] BUS_WR_ADR,
   output logic          BUSY
);

   localparam int DEPTH = 1 << AW;
   localparam logic [3:0] LAST_BIT = 4'(TWI_BITS);

   logic sda_s, scl_rise, scl_fall, start_det, stop_det;

   twi_bus_sync u_sync (
      .clk       (CLK_I),
      .rst       (RST_I),
      .scl_i     (TWI_SCL_I),
      .sda_i     (TWI_SDA_I),
      .sda_o     (sda_s),
      .scl_rise  (scl_rise),
      .scl_fall  (scl_fall),
      .start_det (start_det),
      .stop_det  (stop_det)
   );

   twi_state_e    state_q, state_d;
   logic [3:0]    bit_cnt_q, bit_cnt_d;
   logic [7:0]    shreg_q, shreg_d;
   logic [AW-1:0] ptr_q, ptr_d;
   logic          first_q, first_d;
   logic          rw_q, rw_d;
   logic          oen_q, oen_d;
   logic          busy_q, busy_d;
   logic          wr_stb_q, wr_stb_d;
   logic [AW-1:0] wr_adr_q, wr_adr_d;
   logic [7:0]    regs_q [DEPTH];
   logic [7:0]    regs_d [DEPTH];
   logic          bus_we;
   logic [7:0]    rd_byte;

   // Pointer is already advanced when a new read byte starts, so this is always the next byte.
   assign rd_byte = regs_q[ptr_q];

   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      shreg_d   = shreg_q;
      ptr_d     = ptr_q;
      first_d   = first_q;
      rw_d      = rw_q;
      oen_d     = oen_q;
      busy_d    = busy_q;
      wr_stb_d  = 1'b0;
      wr_adr_d  = wr_adr_q;
      bus_we    = 1'b0;

      if (start_det) begin
         state_d   = ST_ADDR;
         bit_cnt_d = '0;
         oen_d     = 1'b0;
      end else if (stop_det) begin
         state_d = ST_IDLE;
         oen_d   = 1'b0;
         busy_d  = 1'b0;
      end else begin
         unique case (state_q)
            ST_IDLE: ;
            ST_ADDR: begin
               if (scl_rise) begin
                  shreg_d   = {shreg_q[6:0], sda_s};
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end else if (scl_fall && bit_cnt_q == LAST_BIT) begin
                  if (shreg_q[7:1] == SLV_ADDR) begin
                     state_d = ST_ADDR_ACK;
                     rw_d    = shreg_q[0];
                     oen_d   = 1'b1;
                     busy_d  = 1'b1;
                  end else begin
                     state_d = ST_IDLE;
                     oen_d   = 1'b0;
                     busy_d  = 1'b0;
                  end
               end
            end
            ST_ADDR_ACK: begin
               if (scl_fall) begin
                  if (rw_q) begin
                     state_d   = ST_RD_DATA;
                     shreg_d   = rd_byte;
                     oen_d     = ~rd_byte[7];
                     bit_cnt_d = 4'd1;
                  end else begin
                     state_d   = ST_WR_DATA;
                     first_d   = 1'b1;
                     oen_d     = 1'b0;
                     bit_cnt_d = '0;
                  end
               end
            end
            ST_WR_DATA: begin
               if (scl_rise) begin
                  shreg_d   = {shreg_q[6:0], sda_s};
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end else if (scl_fall && bit_cnt_q == LAST_BIT) begin
                  state_d = ST_WR_ACK;
                  oen_d   = 1'b1;
                  if (first_q) begin
                     ptr_d   = shreg_q[AW-1:0];
                     first_d = 1'b0;
                  end else begin
                     bus_we   = 1'b1;
                     wr_stb_d = 1'b1;
                     wr_adr_d = ptr_q;
                     ptr_d    = ptr_q + AW'(1);
                  end
               end
            end
            ST_WR_ACK: begin
               if (scl_fall) begin
                  state_d   = ST_WR_DATA;
                  oen_d     = 1'b0;
                  bit_cnt_d = '0;
               end
            end
            ST_RD_DATA: begin
               // bit_cnt counts bits already placed on the bus.
               if (scl_fall) begin
                  if (bit_cnt_q == LAST_BIT) begin
                     state_d = ST_RD_ACK;
                     oen_d   = 1'b0;
                     ptr_d   = ptr_q + AW'(1);
                  end else begin
                     oen_d     = ~shreg_q[6];
                     shreg_d   = {shreg_q[6:0], 1'b0};
                     bit_cnt_d = bit_cnt_q + 4'd1;
                  end
               end
            end
            ST_RD_ACK: begin
               if (scl_rise && sda_s) begin
                  state_d = ST_IDLE;
                  busy_d  = 1'b0;
               end else if (scl_fall) begin
                  state_d   = ST_RD_DATA;
                  shreg_d   = rd_byte;
                  oen_d     = ~rd_byte[7];
                  bit_cnt_d = 4'd1;
               end
            end
            default: begin
               state_d = ST_IDLE;
               oen_d   = 1'b0;
               busy_d  = 1'b0;
            end
         endcase
      end
   end

   // Bus write is applied last so it overrides a local write to the same address.
   always_comb begin
      regs_d = regs_q;
      if (LOC_WE) begin
         regs_d[LOC_ADR] = LOC_DAT_I;
      end
      if (bus_we) begin
         regs_d[ptr_q] = shreg_q;
      end
   end

   always_ff @(posedge CLK_I or posedge RST_I) begin
      if (RST_I) begin
         state_q   <= ST_IDLE;
         bit_cnt_q <= '0;
         shreg_q   <= '0;
         ptr_q     <= '0;
         first_q   <= 1'b0;
         rw_q      <= 1'b0;
         oen_q     <= 1'b0;
         busy_q    <= 1'b0;
         wr_stb_q  <= 1'b0;
         wr_adr_q  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         shreg_q   <= shreg_d;
         ptr_q     <= ptr_d;
         first_q   <= first_d;
         rw_q      <= rw_d;
         oen_q     <= oen_d;
         busy_q    <= busy_d;
         wr_stb_q  <= wr_stb_d;
         wr_adr_q  <= wr_adr_d;
         for (int i = 0; i < DEPTH; i++) begin
            regs_q[i] <= regs_d[i];
         end
      end
   end

   assign TWI_SDA_OEN = oen_q;
   assign BUSY        = busy_q;
   assign BUS_WR_STB  = wr_stb_q;
   assign BUS_WR_ADR  = wr_adr_q;
   assign LOC_DAT_O   = regs_q[LOC_ADR];

endmodule

// File: tb/tb_twi_slave.sv
// tb/tb_twi_slave.sv - self-checking bench for twi_slave with a bus master model and register model
module tb_twi_slave;

   localparam int AW    = 3;
   localparam int DEPTH = 8;
   localparam int Q     = 10;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          m_scl = 1'b1;
   logic          m_sda = 1'b1;
   logic          sda_oen;
   logic          loc_we = 1'b0;
   logic [AW-1:0] loc_adr = '0;
   logic [7:0]    loc_dat_i = '0;
   logic [7:0]    loc_dat_o;
   logic          bus_wr_stb;
   logic [AW-1:0] bus_wr_adr;
   logic          busy;
   logic          sda_line;

   int            n_chk = 0;
   int            n_fail = 0;
   logic [7:0]    mregs [DEPTH];
   int            mptr = 0;
   int            stb_addrs[$];
   int            exp_stb[$];
   int            oen_cnt = 0;

   assign sda_line = m_sda & ~sda_oen;

   always #5 clk = ~clk;

   twi_slave #(.SLV_ADDR(7'h50), .AW(AW)) dut (
      .CLK_I       (clk),
      .RST_I       (rst),
      .TWI_SCL_I   (m_scl),
      .TWI_SDA_I   (sda_line),
      .TWI_SDA_OEN (sda_oen),
      .LOC_WE      (loc_we),
      .LOC_ADR     (loc_adr),
      .LOC_DAT_I   (loc_dat_i),
      .LOC_DAT_O   (loc_dat_o),
      .BUS_WR_STB  (bus_wr_stb),
      .BUS_WR_ADR  (bus_wr_adr),
      .BUSY        (busy)
   );

   always @(negedge clk) begin
      if (bus_wr_stb === 1'b1) stb_addrs.push_back(int'(bus_wr_adr));
      if (sda_oen === 1'b1) oen_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wclk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic bus_start;
      m_sda = 1'b1; wclk(Q/2);
      m_scl = 1'b1; wclk(Q);
      m_sda = 1'b0; wclk(Q);
      m_scl = 1'b0; wclk(Q/2);
   endtask

   task automatic bus_stop;
      m_sda = 1'b0; wclk(Q/2);
      m_scl = 1'b1; wclk(Q);
      m_sda = 1'b1; wclk(Q);
   endtask

   task automatic write_bit(input logic b);
      m_sda = b;    wclk(Q/2);
      m_scl = 1'b1; wclk(Q);
      m_scl = 1'b0; wclk(Q/2);
   endtask

   task automatic read_bit(output logic b);
      m_sda = 1'b1; wclk(Q/2);
      m_scl = 1'b1; wclk(Q/2);
      b = sda_line; wclk(Q/2);
      m_scl = 1'b0; wclk(Q/2);
   endtask

   task automatic write_byte(input logic [7:0] d, output logic ack);
      logic b;
      for (int i = 7; i >= 0; i--) write_bit(d[i]);
      read_bit(b);
      ack = ~b;
   endtask

   task automatic read_byte(output logic [7:0] d, input logic master_ack);
      logic b;
      d = '0;
      for (int i = 0; i < 8; i++) begin
         read_bit(b);
         d = {d[6:0], b};
      end
      write_bit(~master_ack);
   endtask

   task automatic local_write(input int a, input logic [7:0] d);
      loc_adr = AW'(a); loc_dat_i = d; loc_we = 1'b1;
      wclk(1);
      loc_we = 1'b0;
      mregs[a] = d;
   endtask

   task automatic check_regs(input string tag);
      for (int i = 0; i < DEPTH; i++) begin
         loc_adr = AW'(i);
         #1;
         check($sformatf("%s_reg%0d", tag, i), 32'(loc_dat_o), 32'(mregs[i]));
      end
   endtask

   task automatic check_strobes(input string tag);
      check($sformatf("%s_stb_count", tag), 32'(stb_addrs.size()), 32'(exp_stb.size()));
      for (int i = 0; i < exp_stb.size() && i < stb_addrs.size(); i++)
         check($sformatf("%s_stb_adr%0d", tag, i), 32'(stb_addrs[i]), 32'(exp_stb[i]));
   endtask

   task automatic set_ptr(input int p);
      logic ok;
      int nack = 0;
      bus_start;
      write_byte(8'hA0, ok); if (!ok) nack++;
      write_byte(8'(p), ok); if (!ok) nack++;
      check("ptr_acks", 32'(nack), 32'd0);
      mptr = p % DEPTH;
   endtask

   task automatic tx_write(input int p, input logic [7:0] data[$]);
      logic ok;
      int nack = 0;
      set_ptr(p);
      foreach (data[k]) begin
         write_byte(data[k], ok);
         if (!ok) nack++;
         mregs[mptr] = data[k];
         exp_stb.push_back(mptr);
         mptr = (mptr + 1) % DEPTH;
      end
      bus_stop;
      check("wr_data_acks", 32'(nack), 32'd0);
      check("wr_busy_after_stop", 32'(busy), 32'd0);
   endtask

   task automatic tx_read(input int n, output logic [7:0] got[$]);
      logic ok;
      logic [7:0] d;
      got = {};
      bus_start;
      write_byte(8'hA1, ok);
      check("rd_addr_ack", 32'(ok), 32'd1);
      for (int k = 0; k < n; k++) begin
         read_byte(d, k < n - 1);
         got.push_back(d);
         check($sformatf("rd_byte%0d", k), 32'(d), 32'(mregs[mptr]));
         mptr = (mptr + 1) % DEPTH;
      end
      check("rd_oen_after_nack", 32'(sda_oen), 32'd0);
      check("rd_busy_after_nack", 32'(busy), 32'd0);
      bus_stop;
   endtask

   initial begin
      logic       ok;
      logic [7:0] wq[$];
      logic [7:0] got[$];
      int         oen_snap, stb_snap;

      for (int i = 0; i < DEPTH; i++) mregs[i] = '0;

      wclk(3);
      check("rst_oen", 32'(sda_oen), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_stb", 32'(bus_wr_stb), 32'd0);
      check("rst_wr_adr", 32'(bus_wr_adr), 32'd0);
      rst = 1'b0;
      wclk(3);
      check_regs("rst");

      // Address-match write
      wq = {};
      wq.push_back(8'h5A); wq.push_back(8'hC3);
      tx_write(8'h02, wq);
      loc_adr = 3'd2; #1; check("w1_reg2", 32'(loc_dat_o), 32'h5A);
      loc_adr = 3'd3; #1; check("w1_reg3", 32'(loc_dat_o), 32'hC3);
      check_strobes("w1");

      // Random read with repeated START
      set_ptr(8'h03);
      tx_read(2, got);
      check("rs_byte0_const", 32'(got[0]), 32'hC3);
      check("rs_byte1_const", 32'(got[1]), 32'h00);
      tx_read(1, got);

      // Address mismatch
      oen_snap = oen_cnt;
      stb_snap = stb_addrs.size();
      bus_start;
      write_byte(8'h90, ok); check("mm_addr_nack", 32'(ok), 32'd0);
      write_byte(8'h11, ok); check("mm_data_nack", 32'(ok), 32'd0);
      check("mm_oen_quiet", 32'(oen_cnt), 32'(oen_snap));
      check("mm_busy", 32'(busy), 32'd0);
      check("mm_no_stb", 32'(stb_addrs.size()), 32'(stb_snap));
      bus_start;
      write_byte(8'hA0, ok); check("mm_next_ack", 32'(ok), 32'd1);
      check("mm_next_busy", 32'(busy), 32'd1);
      bus_stop;
      check("mm_stop_busy", 32'(busy), 32'd0);

      // Pointer wrap
      wq = {};
      wq.push_back(8'h11); wq.push_back(8'h22);
      tx_write(8'h07, wq);
      loc_adr = 3'd7; #1; check("wrap_reg7", 32'(loc_dat_o), 32'h11);
      loc_adr = 3'd0; #1; check("wrap_reg0", 32'(loc_dat_o), 32'h22);
      set_ptr(8'h07);
      tx_read(2, got);

      // STOP after 4 data bits aborts the byte
      stb_snap = stb_addrs.size();
      set_ptr(8'h04);
      for (int i = 0; i < 4; i++) write_bit(1'b1);
      bus_stop;
      check("abort_no_stb", 32'(stb_addrs.size()), 32'(stb_snap));
      check_regs("abort");
      tx_read(1, got);

      // Local and bus write collide on address 1
      set_ptr(8'h01);
      for (int i = 7; i >= 1; i--) write_bit(logic'((8'h33 >> i) & 1));
      m_sda = 1'b1; wclk(Q/2);
      m_scl = 1'b1; wclk(Q);
      m_scl = 1'b0; wclk(2);
      loc_adr = 3'd1; loc_dat_i = 8'hEE; loc_we = 1'b1;
      wclk(1);
      loc_we = 1'b0;
      check("col_stb", 32'(bus_wr_stb), 32'd1);
      wclk(Q/2 - 3);
      read_bit(ok);
      check("col_ack", 32'(ok), 32'd0);
      bus_stop;
      mregs[1] = 8'h33;
      exp_stb.push_back(1);
      loc_adr = 3'd1; #1; check("col_reg1", 32'(loc_dat_o), 32'h33);
      check_strobes("col");

      // Randomized traffic against the register model
      for (int it = 0; it < 6; it++) begin
         int p, n;
         local_write($urandom_range(0, DEPTH - 1), 8'($urandom));
         p = $urandom_range(0, 255);
         n = $urandom_range(1, 4);
         wq = {};
         for (int k = 0; k < n; k++) wq.push_back(8'($urandom));
         tx_write(p, wq);
         set_ptr($urandom_range(0, 255));
         tx_read($urandom_range(1, 4), got);
      end
      check_strobes("rand");
      check_regs("rand");

      // Reset while driving a read bit
      local_write(1, 8'h33);
      set_ptr(8'h01);
      bus_start;
      write_byte(8'hA1, ok);
      check("rr_ack", 32'(ok), 32'd1);
      check("rr_oen_driving", 32'(sda_oen), 32'd1);
      check("rr_busy", 32'(busy), 32'd1);
      #2 rst = 1'b1;
      #1;
      check("rr_oen_async", 32'(sda_oen), 32'd0);
      check("rr_busy_async", 32'(busy), 32'd0);
      m_scl = 1'b1; m_sda = 1'b1;
      wclk(3);
      rst = 1'b0;
      wclk(3);
      for (int i = 0; i < DEPTH; i++) mregs[i] = '0;
      check_regs("rr");
      check("rr_wr_adr", 32'(bus_wr_adr), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
